// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared encodings for the shift sequencer and the universal
//                shift register it drives: command opcodes, downstream mode
//                (s) encodings and the sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Command opcodes. 3'b110 and 3'b111 are also treated as NOP.
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;
    localparam logic [2:0] OP_ROTL = 3'b101;

    // Downstream shift register modes.
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // True for the four ops whose step count comes from cmd_cnt.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) ||
               (op == OP_ROTR) || (op == OP_ROTL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step_cnt
//  Description : Step down-counter for the shift sequencer. Loaded with the
//                number of remaining steps after the current one; counts
//                down once per RUN cycle and flags zero on the final step.
//  Ports       : clk, reset (sync, active-high), load/load_val, dec, zero
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step_cnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Accepts LOAD / SHR / SHL / ROTR / ROTL / NOP commands and
//                sequences a downstream universal shift register through the
//                required number of single-bit steps, then pulses done.
//  Ports       : clk, reset (sync, active-high)
//                cmd_valid/cmd_ready handshake, cmd_op, cmd_cnt, cmd_data,
//                cmd_fill command fields; q feedback from the register;
//                s, par, msb, lsb register controls; busy, done status.
//  Revision    : 1.0 - initial release
// ============================================================================
import shift_pkg::*;

module shift_sequencer #(
    parameter  int W  = 4,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_cnt,
    input  logic [W-1:0]  cmd_data,
    input  logic          cmd_fill,
    input  logic [W-1:0]  q,
    output logic [1:0]    s,
    output logic [W-1:0]  par,
    output logic          msb,
    output logic          lsb,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] c_max_steps = CW'(W);

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;
    logic [2:0]    r_op;
    logic [W-1:0]  r_data;
    logic          r_fill;
    logic          r_done;

    logic          w_accept;
    logic [CW-1:0] w_steps;
    logic          w_start_run;
    logic          w_cnt_zero;
    logic          w_last_step;

    // Only the end bits of q feed the rotates; the rest are deliberately
    // left unconsumed.
    logic          w_unused_q;
    assign w_unused_q = ^q;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    // Step count for the offered command, shift counts clamped to W.
    always_comb begin
        w_steps = '0;
        if (cmd_op == OP_LOAD) begin
            w_steps = CW'(1);
        end else if (is_shift_op(cmd_op)) begin
            w_steps = (cmd_cnt > c_max_steps) ? c_max_steps : cmd_cnt;
        end
    end

    assign w_start_run = w_accept && (w_steps != '0);
    assign w_last_step = (r_state == ST_RUN) && w_cnt_zero;

    // Counter holds the steps remaining after the current RUN cycle, so it
    // is loaded with steps-1 and the zero flag marks the final RUN cycle.
    shift_step_cnt #(
        .CW (CW)
    ) u_step_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_start_run),
        .load_val (w_steps - CW'(1)),
        .dec      (r_state == ST_RUN),
        .zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and downstream control outputs.
    always_comb begin
        w_state_nxt = r_state;
        s           = S_HOLD;
        par         = '0;
        msb         = 1'b0;
        lsb         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end
                case (r_op)
                    OP_LOAD: begin
                        s   = S_LOAD;
                        par = r_data;
                    end
                    OP_SHR: begin
                        s   = S_SHR;
                        msb = r_fill;
                    end
                    OP_SHL: begin
                        s   = S_SHL;
                        lsb = r_fill;
                    end
                    OP_ROTR: begin
                        s   = S_SHR;
                        msb = q[0];
                    end
                    OP_ROTL: begin
                        s   = S_SHL;
                        lsb = q[W-1];
                    end
                    default: begin
                        s = S_HOLD;
                    end
                endcase
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // The register must not move on a reset cycle, even mid-command.
        if (reset) begin
            s   = S_HOLD;
            par = '0;
            msb = 1'b0;
            lsb = 1'b0;
        end
    end

    // Latched command fields and the registered done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= OP_NOP;
            r_data <= '0;
            r_fill <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (w_accept && (w_steps == '0)) || w_last_step;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_fill <= cmd_fill;
            end
        end
    end

endmodule
`default_nettype wire
